tx_cmd_queue: RTL and testbench

//   Front end of the UART TX path; sits between the board inputs and TX.
//   - Synchronises and debounces the push button (botao).
//   - On each debounced press, captures the frame {instrucao, dado}.
//   - Buffers captured frames in a small first-word-fall-through (FWFT) FIFO.
//   - Hands frames to TX over a valid/ready handshake, so presses made while
//     TX is busy are not lost.

---
 rtl/tx_cmd_queue.sv | 107 ++++++++++
 tb/tb_tx_cmd_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_cmd_queue.sv
// UART TX front end: synchronises and debounces the push button, captures
// {instrucao, dado} on each debounced press into a FWFT FIFO read over valid/ready.
module tx_cmd_queue #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DEPTH           = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         botao,
   input  logic [3:0]                   dado,
   input  logic [3:0]                   instrucao,
   input  logic                         tx_ready,
   output logic                         tx_valid,
   output logic [7:0]                   tx_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          sync_1;
   logic          botao_s;
   logic          deb;
   logic [DW-1:0] deb_cnt;
   logic          deb_flip;
   logic          push;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop;
   logic          wr_en;
   logic [CW-1:0] count_next;

   // deb changes on the same edge the counter would reach its limit, and the
   // rising case is the push strobe, so the frame is written on that edge too.
   assign deb_flip = (botao_s != deb) && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
   assign push     = deb_flip & botao_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_1  <= 1'b0;
         botao_s <= 1'b0;
         deb     <= 1'b0;
         deb_cnt <= '0;
      end else begin
         sync_1  <= botao;
         botao_s <= sync_1;
         if (botao_s == deb) begin
            deb_cnt <= '0;
         end else if (deb_flip) begin
            deb     <= botao_s;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   assign tx_valid = !empty;
   assign tx_data  = mem[rd_ptr];
   assign pop      = tx_valid & tx_ready;
   // A pop on the same edge frees a slot, so a press while full still lands.
   assign wr_en    = push & (!full | pop);

   always_comb begin
      count_next = count;
      case ({wr_en, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= {instrucao, dado};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && full && !pop) begin
            overflow <= 1'b1;
         end
         count <= count_next;
         full  <= (count_next == CW'(DEPTH));
         empty <= (count_next == '0);
      end
   end

endmodule

// File: tb/tb_tx_cmd_queue.sv
// Randomised bench for tx_cmd_queue: a press-level reference model feeds an
// expected-frame queue that a monitor drains on every handshake.
module tb_tx_cmd_queue;

   localparam int DEB   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          botao = 1'b0;
   logic [3:0]    dado = 4'h0;
   logic [3:0]    instrucao = 4'h0;
   logic          tx_ready = 1'b0;
   logic          tx_valid;
   logic [7:0]    tx_data;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          overflow;

   tx_cmd_queue #(.DEBOUNCE_CYCLES(DEB), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .botao(botao), .dado(dado), .instrucao(instrucao),
      .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .full(full),
      .empty(empty), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];
   int          occ = 0;
   bit          ovf_m = 1'b0;
   bit          push_now = 1'b0;
   logic [7:0]  word_now = 8'h00;
   bit          rand_ready = 1'b0;
   bit          pop_m;
   logic [7:0]  head_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a press lands on its debounce edge unless the queue is
   // full and nothing leaves on that same edge.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ   = 0;
         ovf_m = 1'b0;
         exp_q.delete();
      end else begin
         pop_m = (occ > 0) && tx_ready;
         if (pop_m) occ--;
         if (push_now) begin
            if (occ < DEPTH) begin
               occ++;
               exp_q.push_back(word_now);
            end else begin
               ovf_m = 1'b1;
            end
         end
      end
   end

   // Monitor: status every cycle, frame contents on every handshake.
   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         check("count", 32'(count), 32'(occ));
         check("full", 32'(full), 32'(occ == DEPTH));
         check("empty", 32'(empty), 32'(occ == 0));
         check("tx_valid", 32'(tx_valid), 32'(occ != 0));
         check("overflow", 32'(overflow), 32'(ovf_m));
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               check("pop_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
               head_exp = exp_q.pop_front();
               check("pop_data", 32'(tx_data), 32'(head_exp));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Button held from one negedge; the debounced push lands on the
   // (2+DEB)-th rising edge afterwards.
   task automatic press(input logic [7:0] w, input bit ready_on_push);
      @(negedge clk);
      instrucao = w[7:4];
      dado      = w[3:0];
      botao     = 1'b1;
      repeat (1 + DEB) @(negedge clk);
      push_now = 1'b1;
      word_now = w;
      if (ready_on_push) tx_ready = 1'b1;
      @(negedge clk);
      push_now = 1'b0;
      if (ready_on_push) tx_ready = 1'b0;
      botao = 1'b0;
      repeat (2 + DEB + 3) @(negedge clk);
   endtask

   task automatic drain();
      @(negedge clk);
      tx_ready = 1'b1;
      repeat (DEPTH + 2) @(negedge clk);
      tx_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
      check({tag, "_tx_data"}, 32'(tx_data), 32'h00);
      check({tag, "_count"}, 32'(count), 32'd0);
      check({tag, "_full"}, 32'(full), 32'd0);
      check({tag, "_empty"}, 32'(empty), 32'd1);
      check({tag, "_overflow"}, 32'(overflow), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Single press with TX stalled
      press(8'h3A, 1'b0);
      #1;
      check("single_head", 32'(tx_data), 32'h3A);
      check("single_count", 32'(count), 32'd1);

      // Bounce shorter than the debounce window: nothing captured
      @(negedge clk);
      botao = 1'b1;
      repeat (3) @(negedge clk);
      botao = 1'b0;
      @(negedge clk);
      botao = 1'b1;
      repeat (2) @(negedge clk);
      botao = 1'b0;
      repeat (12) @(negedge clk);
      #1;
      check("bounce_count", 32'(count), 32'd1);
      drain();

      // Fill past capacity with TX stalled
      for (int i = 1; i <= 5; i++) begin
         press({4'($urandom_range(0, 15)), 4'(i)}, 1'b0);
      end
      #1;
      check("fill_full", 32'(full), 32'd1);
      check("fill_overflow", 32'(overflow), 32'd1);
      drain();

      // Async reset between edges with three frames queued
      for (int i = 0; i < 3; i++) begin
         press(8'($urandom_range(0, 255)), 1'b0);
      end
      @(posedge clk);
      #2;
      check("pre_rst_count", 32'(count), 32'd3);
      rst = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      instrucao = 4'hC;
      dado      = 4'h5;
      botao     = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (1 + DEB) @(negedge clk);
      push_now = 1'b1;
      word_now = 8'hC5;
      @(negedge clk);
      push_now = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      check("held_through_rst_count", 32'(count), 32'd1);
      botao = 1'b0;
      repeat (10) @(negedge clk);
      drain();

      // Press landing on the same edge as a pop while full
      for (int i = 0; i < DEPTH; i++) begin
         press({4'h7, 4'(i)}, 1'b0);
      end
      press(8'hE9, 1'b1);
      #1;
      check("simul_count", 32'(count), 32'd4);
      check("simul_overflow", 32'(overflow), 32'd0);
      drain();

      // Pointer wrap-around with TX always ready
      @(negedge clk);
      tx_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         press(8'($urandom_range(0, 255)), 1'b0);
      end
      tx_ready = 1'b0;
      #1;
      check("wrap_empty", 32'(empty), 32'd1);
      check("wrap_count", 32'(count), 32'd0);

      // Random presses against a randomly stalling TX
      rand_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         press(8'($urandom_range(0, 255)), 1'b0);
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      rand_ready = 1'b0;
      drain();
      #1;
      check("final_leftover", 32'(exp_q.size()), 32'd0);
      check("final_empty", 32'(empty), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
